// File: rtl/idex_pipe_reg.sv
// idex_pipe_reg
//   ID/EX pipeline register for the pipelined MIPS core. Carries a packed
//   control word, NUM_DATA data words and the rs/rt/rd specifiers from decode
//   to execute. It also tracks whether the EX-stage slot holds a real
//   instruction, holds its contents on stall, and inserts a bubble on flush.
//   It detects load-use hazards and tells upstream stages to freeze.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   id_valid              decode stage holds a real instruction
//   id_ctrl               decoded control word (CTRL_W bits)
//   id_data               NUM_DATA packed words, word k at [k*DATA_W +: DATA_W]
//   id_rs/id_rt/id_rd     register specifiers from decode
//   stall                 downstream hold request (register keeps contents)
//   flush                 squash request (inserts a bubble)
//   ex_valid/ex_ctrl/ex_data/ex_rs/ex_rt/ex_rd   registered EX-stage copy
//   lu_stall              combinational load-use hazard flag to upstream
//   perf_bubble_cnt       bubbles inserted (wraps)
//   perf_stall_cnt        cycles held by stall (wraps)
//
// Build option
//   IDEX_PERF_CNT_EN      when defined, the performance counters are built.
//                         When it is undefined, both counter outputs read 0.

module idex_pipe_reg #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NUM_DATA    = 4,
    parameter int unsigned CTRL_W      = 9,
    parameter int unsigned MEMREAD_BIT = 3,
    parameter int unsigned REG_W       = 5,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [CTRL_W-1:0]          id_ctrl,
    input  logic [NUM_DATA*DATA_W-1:0] id_data,
    input  logic [REG_W-1:0]           id_rs,
    input  logic [REG_W-1:0]           id_rt,
    input  logic [REG_W-1:0]           id_rd,
    input  logic                       stall,
    input  logic                       flush,
    output logic                       ex_valid,
    output logic [CTRL_W-1:0]          ex_ctrl,
    output logic [NUM_DATA*DATA_W-1:0] ex_data,
    output logic [REG_W-1:0]           ex_rs,
    output logic [REG_W-1:0]           ex_rt,
    output logic [REG_W-1:0]           ex_rd,
    output logic                       lu_stall,
    output logic [CNT_W-1:0]           perf_bubble_cnt,
    output logic [CNT_W-1:0]           perf_stall_cnt
);

    localparam int unsigned DW = NUM_DATA * DATA_W;

    typedef enum logic [1:0] {
        ACT_LOAD,
        ACT_HOLD,
        ACT_BUBBLE
    } act_e;

    act_e              act;

    logic              ex_valid_q, ex_valid_d;
    logic [CTRL_W-1:0] ex_ctrl_q,  ex_ctrl_d;
    logic [DW-1:0]     ex_data_q,  ex_data_d;
    logic [REG_W-1:0]  ex_rs_q,    ex_rs_d;
    logic [REG_W-1:0]  ex_rt_q,    ex_rt_d;
    logic [REG_W-1:0]  ex_rd_q,    ex_rd_d;

    // A load in EX whose destination (rt) feeds the instruction in ID.
    // Writes to $zero never create a dependency.
    assign lu_stall = id_valid & ex_valid_q & ex_ctrl_q[MEMREAD_BIT] &
                      (ex_rt_q != '0) &
                      ((ex_rt_q == id_rs) | (ex_rt_q == id_rt));

    // Flush beats stall, and stall beats the load-use bubble. While stalled,
    // the hazard stays visible so that upstream remains frozen.
    always_comb begin
        if (flush)         act = ACT_BUBBLE;
        else if (stall)    act = ACT_HOLD;
        else if (lu_stall) act = ACT_BUBBLE;
        else               act = ACT_LOAD;
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_ctrl_d  = ex_ctrl_q;
        ex_data_d  = ex_data_q;
        ex_rs_d    = ex_rs_q;
        ex_rt_d    = ex_rt_q;
        ex_rd_d    = ex_rd_q;
        case (act)
            ACT_LOAD: begin
                ex_valid_d = id_valid;
                ex_ctrl_d  = id_ctrl;
                ex_data_d  = id_data;
                ex_rs_d    = id_rs;
                ex_rt_d    = id_rt;
                ex_rd_d    = id_rd;
            end
            // A bubble clears only valid and control. The data and specifiers
            // are kept, because a zero control word makes them inert.
            ACT_BUBBLE: begin
                ex_valid_d = 1'b0;
                ex_ctrl_d  = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            ex_data_q  <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_rd_q    <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_data_q  <= ex_data_d;
            ex_rs_q    <= ex_rs_d;
            ex_rt_q    <= ex_rt_d;
            ex_rd_q    <= ex_rd_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_ctrl  = ex_ctrl_q;
    assign ex_data  = ex_data_q;
    assign ex_rs    = ex_rs_q;
    assign ex_rt    = ex_rt_q;
    assign ex_rd    = ex_rd_q;

`ifdef IDEX_PERF_CNT_EN
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;

    // Counters wrap naturally at 2^CNT_W.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(act == ACT_BUBBLE);
        stall_cnt_d  = stall_cnt_q  + CNT_W'(act == ACT_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign perf_bubble_cnt = bubble_cnt_q;
    assign perf_stall_cnt  = stall_cnt_q;
`else
    assign perf_bubble_cnt = '0;
    assign perf_stall_cnt  = '0;
`endif

endmodule
